// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive sequencer for baud generator, external shift register and frame buffer.
// Optional parity stage between DATA and STOP: define UART_RX_CTRL_PARITY_EN.
module uart_rx_ctrl #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = $clog2(DATA_BITS+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 rx,
   input  logic                 baud_tick,
   output logic                 baud_rst,
   output logic                 bit_strobe,
   output logic                 bit_value,
   input  logic [DATA_BITS-1:0] frame_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 start_glitch,
   output logic                 parity_err,
   output logic                 overrun,
   input  logic                 clr_overrun,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_WIDTH-1:0] cnt;
   logic rx_s, rx_q, tk, last, bad, deliver;

   assign rx_s     = sync[SYNC_STAGES-1];
   assign tk       = enable && baud_tick;
   assign last     = cnt == CNT_WIDTH'(DATA_BITS-1);
   assign baud_rst = state == IDLE;
   assign busy     = state != IDLE;
   assign deliver  = tk && state == STOP && rx_s && !bad;

`ifdef UART_RX_CTRL_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
   logic par, par_bad;
   assign bad = par_bad;
   // par accumulates the data bits; a correct even-parity bit equals it
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         par        <= 1'b0;
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= tk && state == PARITY && rx_s != par;
         if (state == START) begin
            par     <= 1'b0;
            par_bad <= 1'b0;
         end else if (tk && state == DATA)
            par <= par ^ rx_s;
         else if (tk && state == PARITY)
            par_bad <= rx_s != par;
      end
`else
   localparam state_t AFTER_DATA = STOP;
   assign bad        = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      if (!enable) state_n = IDLE;
      else
         case (state)
            IDLE:    if (rx_q && !rx_s) state_n = START;
            START:   if (baud_tick) state_n = rx_s ? IDLE : DATA;
            DATA:    if (baud_tick && last) state_n = AFTER_DATA;
            PARITY:  if (baud_tick) state_n = STOP;
            STOP:    if (baud_tick) state_n = IDLE;
            default: state_n = IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sync         <= '1;
         rx_q         <= 1'b1;
         cnt          <= '0;
         bit_strobe   <= 1'b0;
         bit_value    <= 1'b1;
         frame_err    <= 1'b0;
         start_glitch <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sync         <= {sync[SYNC_STAGES-2:0], rx};
         rx_q         <= rx_s;
         cnt          <= state == START ? '0 : (tk && state == DATA) ? cnt + 1'b1 : cnt;
         bit_strobe   <= tk && state == DATA;
         if (tk && state == DATA) bit_value <= rx_s;
         frame_err    <= tk && state == STOP && !rx_s;
         start_glitch <= tk && state == START && rx_s;
         // a frame is accepted only when the buffer is empty or being read this cycle
         if (deliver && (!data_valid || data_ready)) begin
            data_out   <= frame_in;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready)
            data_valid <= 1'b0;
         overrun <= (deliver && data_valid && !data_ready) || (overrun && !clr_overrun);
      end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized serial frames for uart_rx_ctrl,
// checked against a frame-outcome reference model.
module tb_uart_rx_ctrl;
`ifdef UART_RX_CTRL_PARITY_EN
   localparam int STOP_TICK = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int STOP_TICK = 10;
   localparam bit PAR = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, enable = 1'b0, rx = 1'b1, clr_overrun = 1'b0;
   logic ready_lvl = 1'b0, arm = 1'b0;
   logic baud_tick, data_ready, baud_rst, bit_strobe, bit_value, data_valid;
   logic frame_err, start_glitch, parity_err, overrun, busy;
   logic [7:0] frame_in = 8'hFF;
   logic [7:0] data_out;
   int bcnt = 0, tcnt = 0;
   int n_stb = 0, n_ferr = 0, n_glitch = 0, n_perr = 0, n_vcyc = 0;
   logic [7:0] exp_out = 8'h00;
   bit exp_valid = 1'b0, exp_ovr = 1'b0;
   int exp_stb = 0, exp_ferr = 0, exp_perr = 0, exp_glitch = 0;
   int passes = 0, fails = 0, total = 0;

   uart_rx_ctrl dut (
      .clk(clk), .rst(rst), .enable(enable), .rx(rx), .baud_tick(baud_tick),
      .baud_rst(baud_rst), .bit_strobe(bit_strobe), .bit_value(bit_value),
      .frame_in(frame_in), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .frame_err(frame_err), .start_glitch(start_glitch),
      .parity_err(parity_err), .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // baud generator: first tick half a bit (8 clk) after release, then every 16 clk
   always @(posedge clk) bcnt <= baud_rst ? 0 : bcnt + 1;
   assign baud_tick = !baud_rst && (bcnt % 16 == 7);
   always @(posedge clk) tcnt <= baud_rst ? 0 : tcnt + (baud_tick ? 1 : 0);
   assign data_ready = ready_lvl | (arm & baud_tick & (tcnt == STOP_TICK - 1));

   // external shift register (LSB first) plus pulse counters
   always @(posedge clk) begin
      if (bit_strobe) begin
         frame_in <= {bit_value, frame_in[7:1]};
         n_stb    <= n_stb + 1;
      end
      n_ferr   <= n_ferr + int'(frame_err);
      n_glitch <= n_glitch + int'(start_glitch);
      n_perr   <= n_perr + int'(parity_err);
      n_vcyc   <= n_vcyc + int'(data_valid);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_bad);
      rx = 1'b0;
      hold(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         hold(16);
      end
      if (PAR) begin
         rx = (^b) ^ par_bad;
         hold(16);
      end
      rx = stop_bit;
      hold(16);
      rx = 1'b1;
      hold(4);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_out"}, 32'(data_out), 32'(exp_out));
      chk({tag, "_valid"}, 32'(data_valid), 32'(exp_valid));
      chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
      chk({tag, "_stb"}, n_stb, exp_stb);
      chk({tag, "_ferr"}, n_ferr, exp_ferr);
      chk({tag, "_perr"}, n_perr, exp_perr);
      chk({tag, "_glitch"}, n_glitch, exp_glitch);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_baudrst"}, 32'(baud_rst), 1);
   endtask

   // reference: outcome of one whole frame under a constant data_ready level
   task automatic frame(input string tag, input logic [7:0] b, input logic stop_bit,
                        input logic par_bad, input logic rdy);
      logic bad;
      bad = PAR & par_bad;
      ready_lvl = rdy;
      if (rdy) exp_valid = 1'b0;
      send(b, stop_bit, bad);
      exp_stb += 8;
      if (bad) exp_perr++;
      if (!stop_bit) exp_ferr++;
      else if (!bad) begin
         if (!exp_valid) begin
            exp_out   = b;
            exp_valid = !rdy;
         end else exp_ovr = 1'b1;
      end
      chk({tag, "_bits"}, 32'(frame_in), 32'(b));
      chk_all(tag);
   endtask

   task automatic clear_ovr(input string tag);
      clr_overrun = 1'b1;
      hold(1);
      clr_overrun = 1'b0;
      exp_ovr = 1'b0;
      chk(tag, 32'(overrun), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_baudrst"}, 32'(baud_rst), 1);
      chk({tag, "_bitval"}, 32'(bit_value), 1);
      chk({tag, "_strobe"}, 32'(bit_strobe), 0);
      chk({tag, "_valid"}, 32'(data_valid), 0);
      chk({tag, "_out"}, 32'(data_out), 0);
      chk({tag, "_ovr"}, 32'(overrun), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_errs"}, {29'd0, frame_err, start_glitch, parity_err}, 0);
   endtask

   initial begin
      int v0;
      logic [7:0] b;
      hold(3);
      chk_reset("reset");
      rst = 1'b1;
      enable = 1'b1;
      hold(4);

      v0 = n_vcyc;
      frame("a5", 8'hA5, 1'b1, 1'b0, 1'b1);
      chk("a5_vcyc", n_vcyc - v0, 1);

      rx = 1'b0;
      hold(3);
      rx = 1'b1;
      hold(24);
      exp_glitch++;
      chk_all("glitch");

      frame("ferr", 8'h3C, 1'b0, 1'b0, 1'b1);

      frame("ovr1", 8'h11, 1'b1, 1'b0, 1'b0);
      frame("ovr2", 8'h22, 1'b1, 1'b0, 1'b0);
      clear_ovr("ovr_clr");

      ready_lvl = 1'b1;
      hold(2);
      exp_valid = 1'b0;
      frame("edge1", 8'h11, 1'b1, 1'b0, 1'b0);
      arm = 1'b1;
      send(8'h22, 1'b1, 1'b0);
      arm = 1'b0;
      exp_stb += 8;
      exp_out = 8'h22;
      exp_valid = 1'b1;
      chk_all("edge2");

      ready_lvl = 1'b1;
      hold(2);
      exp_valid = 1'b0;
      rx = 1'b0;
      hold(40);
      enable = 1'b0;
      hold(2);
      exp_stb += 1;
      chk_all("enable");
      rx = 1'b1;
      hold(200);
      enable = 1'b1;
      hold(4);

      b = 8'h5A;
      rx = 1'b0;
      hold(16);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         hold(16);
      end
      rx = b[3];
      hold(8);
      rst = 1'b0;
      #1;
      exp_stb += 3;
      chk_reset("midrst");
      exp_out = 8'h00;
      exp_valid = 1'b0;
      exp_ovr = 1'b0;
      rx = 1'b1;
      hold(3);
      rst = 1'b1;
      hold(30);
      frame("after_rst", 8'h5A, 1'b1, 1'b0, 1'b1);
      if (PAR) frame("par_bad", 8'h5A, 1'b1, 1'b1, 1'b1);

      for (int k = 0; k < 12; k++) begin
         frame("rnd", 8'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
         if (exp_ovr && $urandom_range(0, 1) == 1) clear_ovr("rnd_clr");
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive sequencer for the serial capture path: baud generator, external shift register, frame buffer.
- Detects the start edge and holds or releases the baud generator.
- Qualifies each data bit for the shift register, then latches the parallel frame.
- Checks the stop bit and hands the frame to the readout side with a valid/ready handshake.
- Replaces the ad-hoc two-driver start/stop logic with one synchronous state machine in the clk domain.

Parameters:
- DATA_BITS, 8, number of data bits per frame (1..16).
- SYNC_STAGES, 2, flip-flop stages on rx before use (>=2).
- CNT_WIDTH, $clog2(DATA_BITS+1), width of the bit counter.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  high = receiver armed; low = forced to IDLE.
- rx  in  1  raw serial line; idles high.
- baud_tick  in  1  one-clk strobe from the baud generator at each bit centre.
- baud_rst  out  1  high = hold the baud generator in reset.
- bit_strobe  out  1  one-clk pulse; the shift register shifts in bit_value.
- bit_value  out  1  sampled data bit, valid while bit_strobe is high.
- frame_in  in  DATA_BITS  parallel output of the shift register.
- data_out  out  DATA_BITS  buffered frame.
- data_valid  out  1  data_out holds an unread frame.
- data_ready  in  1  consumer accepts data_out when data_valid is high.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- start_glitch  out  1  one-clk pulse: start bit not low at its centre.
- parity_err  out  1  one-clk pulse; see Optional Feature.
- overrun  out  1  sticky: a completed frame was dropped.
- clr_overrun  in  1  synchronous clear for overrun.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - baud_rst=1, bit_value=1.
  - bit_strobe, data_valid, frame_err, start_glitch, parity_err, overrun, busy all 0.
  - data_out=0, state=IDLE, bit counter=0.
- rx passes through SYNC_STAGES flops to give rx_s; edge detection uses rx_s and its previous value.
- Baud generator contract:
  - First baud_tick arrives a half bit period after baud_rst falls.
  - Subsequent ticks arrive every bit period.
- States: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE:
  - baud_rst=1.
  - rx_s falling (1 to 0) with enable=1 -> START. baud_rst goes 0 on the same edge as the state change.
- START, on baud_tick:
  - rx_s=0 -> DATA, counter=0.
  - rx_s=1 -> pulse start_glitch, go to IDLE.
- DATA, on baud_tick:
  - Register bit_value=rx_s and pulse bit_strobe in the following cycle (latency 1 clk).
  - Increment counter. When counter reaches DATA_BITS-1 on a tick -> STOP (or PARITY).
- STOP, on baud_tick:
  - rx_s=1: the frame is good and is delivered to the buffer.
  - rx_s=0: pulse frame_err and discard the frame.
  - Either way -> IDLE and baud_rst=1.
- Delivery to the buffer:
  - If data_valid=0, or data_valid=1 with data_ready=1 in the same cycle: data_out<=frame_in, data_valid<=1.
  - Otherwise data_out is kept, the new frame is dropped, and overrun<=1.
- Handshake: data_valid clears on the first clk where data_valid && data_ready, unless a new delivery happens that same cycle.
- overrun:
  - Clears on clr_overrun.
  - A set and a clear in the same cycle leave overrun=1.
- enable low in any state: next clk -> IDLE, baud_rst=1. No error pulses, and the buffer is unchanged.
- Reset asserted mid-frame: immediate return to reset values; a partial frame is never delivered.
- baud_tick in IDLE is ignored.
- Boundary: with DATA_BITS=1, DATA lasts exactly one tick.

Optional Feature:
- Macro: UART_RX_CTRL_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP and consumes one baud_tick.
  - The expected bit is even parity over the data bits sampled in DATA, tracked internally.
  - Mismatch -> parity_err pulse; the frame is still taken through STOP but is not delivered.
- Undefined:
  - No PARITY state; the stop bit is the bit after the last data bit.
  - parity_err tied 0.

Test Plan:
- Frame 0xA5 (LSB first, stop=1), tick every 16 clk, data_ready=1: 8 bit_strobe pulses with values 1,0,1,0,0,1,0,1; data_out=0xA5; data_valid high for 1 clk; no error pulses.
- rx low for 3 clk then high before the first tick: start_glitch pulses once; state returns to IDLE; baud_rst returns to 1; no bit_strobe.
- Frame 0x3C with stop bit=0: frame_err pulses once; data_valid stays 0; data_out unchanged from before.
- Two frames 0x11 then 0x22 with data_ready=0: data_out=0x11, overrun=1; after clr_overrun, overrun=0.
- Same two frames with data_ready=1 on exactly the cycle the second stop tick completes: data_out=0x22, overrun=0.
- rst low during the 4th data bit, then a clean 0x5A frame: outputs return to reset values immediately; the next frame yields data_out=0x5A. With UART_RX_CTRL_PARITY_EN, a wrong parity bit gives a parity_err pulse and no delivery.
